// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame FSM states and the
// default frame geometry used by the start-bit, 24-count and deframer blocks.
package uart_rx_pkg;

    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam int unsigned DEF_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: counts enabled ticks 0..OVERSAMPLE-1 and flags the
// tick that completes a bit period (the next bit centre).
module uart_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic mid_bit
);

    localparam int unsigned   CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise advance on enabled ticks and wrap at LAST
    always_comb begin
        cnt_d   = cnt_q;
        mid_bit = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && tick) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                mid_bit = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: starting from the centre of data bit 0, samples each
// following bit centre, assembles the data word LSB-first, checks parity and
// stop bit, and reports the byte with valid/error flags and a frame_done pulse.
module uart_rx_deframer
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_sample_ENABLE,
    input  logic                 RxD,
    input  logic                 enable_twentyfour,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_busy,
    output logic                 frame_done
);

    localparam int unsigned BW = $clog2(DATA_BITS + 3);

    rx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perror_q, perror_d;
    logic                 ferror_q, ferror_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 mid_bit;
    logic                 last_data;

    // Timer is held at zero while idle, so a tick coincident with the start pulse is not counted
    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == IDLE),
        .enable (state_q != IDLE),
        .tick   (Rx_sample_ENABLE),
        .mid_bit(mid_bit)
    );

    assign last_data = (bit_idx_q == BW'(DATA_BITS - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perror_q  <= 1'b0;
            ferror_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perror_q  <= perror_d;
            ferror_q  <= ferror_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state: advance one field per bit-centre sample; start pulses outside IDLE are ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_twentyfour) state_d = DATA;
            DATA:    if (mid_bit && last_data) state_d = PARITY_EN ? PARITY : STOP;
            PARITY:  if (mid_bit) state_d = STOP;
            STOP:    if (mid_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and flag updates taken at the start pulse and at each bit-centre sample
    always_comb begin
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perror_d  = perror_q;
        ferror_d  = ferror_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_twentyfour) begin
                    shift_d    = '0;
                    shift_d[0] = RxD;
                    bit_idx_d  = BW'(1);
                    perror_d   = 1'b0;
                    ferror_d   = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            DATA: begin
                if (mid_bit) begin
                    for (int unsigned i = 0; i < DATA_BITS; i++) begin
                        if (bit_idx_q == BW'(i)) shift_d[i] = RxD;
                    end
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            PARITY: begin
                if (mid_bit) perror_d = ((^shift_q) ^ RxD) != PARITY_ODD;
            end
            STOP: begin
                if (mid_bit) begin
                    ferror_d = ~RxD;
                    data_d   = shift_q;
                    valid_d  = RxD & ~perror_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign Rx_DATA    = data_q;
    assign Rx_VALID   = valid_q;
    assign Rx_PERROR  = perror_q;
    assign Rx_FERROR  = ferror_q;
    assign Rx_busy    = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: an 8E1 instance and an 8N1 instance,
// frames driven bit-by-bit with a sample tick every 4 clocks.
module tb_uart_rx_deframer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, tick, rxd, e24_e, e24_n;

    logic [7:0] data_e, data_n;
    logic       valid_e, perror_e, ferror_e, busy_e, done_e;
    logic       valid_n, perror_n, ferror_n, busy_n, done_n;

    uart_rx_deframer #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Rx_sample_ENABLE (tick),
        .RxD              (rxd),
        .enable_twentyfour(e24_e),
        .Rx_DATA          (data_e),
        .Rx_VALID         (valid_e),
        .Rx_PERROR        (perror_e),
        .Rx_FERROR        (ferror_e),
        .Rx_busy          (busy_e),
        .frame_done       (done_e)
    );

    uart_rx_deframer #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_EN (1'b0),
        .PARITY_ODD(1'b0)
    ) dut_n (
        .clk              (clk),
        .reset            (reset),
        .Rx_sample_ENABLE (tick),
        .RxD              (rxd),
        .enable_twentyfour(e24_n),
        .Rx_DATA          (data_n),
        .Rx_VALID         (valid_n),
        .Rx_PERROR        (perror_n),
        .Rx_FERROR        (ferror_n),
        .Rx_busy          (busy_n),
        .frame_done       (done_n)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned cur_tick, valid_cnt, done_cnt, valid_tick, done_tick;
    bit          use_n;

    typedef struct {
        string       name;
        logic [15:0] line;        // line bits in send order, bit 0 = data bit 0
        int unsigned nbits;       // bits from data bit 0 through stop
        bit          glitch;
        bit          on_n;
        int unsigned e24_again;   // tick after which a stray start pulse is sent (0 = none)
        logic [7:0]  exp_data;
        int unsigned exp_valid;
        int unsigned exp_vtick;
        logic        exp_perr;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cur_busy();
        return use_n ? busy_n : busy_e;
    endfunction

    function automatic logic [1:0] cur_errs();
        return use_n ? {perror_n, ferror_n} : {perror_e, ferror_e};
    endfunction

    // One clock: drive inputs on the falling edge, observe just after the rising edge
    task automatic clk_cycle(input logic t, input logic r, input logic e);
        logic v, d;
        @(negedge clk);
        tick = t;
        rxd  = r;
        e24_e = use_n ? 1'b0 : e;
        e24_n = use_n ? e : 1'b0;
        @(posedge clk);
        #1;
        if (t) cur_tick++;
        v = use_n ? valid_n : valid_e;
        d = use_n ? done_n : done_e;
        if (v) begin valid_cnt++; valid_tick = cur_tick; end
        if (d) begin done_cnt++;  done_tick  = cur_tick; end
    endtask

    task automatic clear_mon();
        cur_tick = 0; valid_cnt = 0; done_cnt = 0; valid_tick = 0; done_tick = 0;
    endtask

    task automatic send_frame(input string name, input logic [15:0] line, input int unsigned nbits,
                              input bit glitch, input int unsigned abort_tick,
                              input int unsigned e24_again);
        int unsigned total;
        logic b, rv;
        total = 16 * (nbits - 1);
        clear_mon();
        clk_cycle(1'b0, line[0], 1'b1);
        chk({name, "_busy_at_start"}, 32'(cur_busy()), 32'd1);
        chk({name, "_errs_cleared"}, 32'(cur_errs()), 32'd0);
        for (int unsigned k = 1; k <= total; k++) begin
            b = line[4'((k + 8) / 16)];
            for (int unsigned c = 0; c < 3; c++) begin
                rv = (glitch && (k % 16 == 0) && c == 1) ? 1'b0 : b;
                clk_cycle(1'b0, rv, (e24_again != 0 && k == e24_again + 1 && c == 0));
            end
            clk_cycle(1'b1, b, 1'b0);
            if (abort_tick != 0 && k == abort_tick) return;
        end
        for (int unsigned c = 0; c < 32; c++) clk_cycle((c % 4) == 3, 1'b1, 1'b0);
    endtask

    initial begin
        vecs[0] = '{"a5_8e1",         16'h02A5, 10, 1'b0, 1'b0, 0,  8'hA5, 1, 144, 1'b0, 1'b0};
        vecs[1] = '{"3c_bad_parity",  16'h033C, 10, 1'b0, 1'b0, 0,  8'h3C, 0, 0,   1'b1, 1'b0};
        vecs[2] = '{"ff_bad_stop",    16'h00FF, 10, 1'b0, 1'b0, 0,  8'hFF, 0, 0,   1'b0, 1'b1};
        vecs[3] = '{"01_after_ferr",  16'h0301, 10, 1'b0, 1'b0, 0,  8'h01, 1, 144, 1'b0, 1'b0};
        vecs[4] = '{"55_glitched",    16'h0255, 10, 1'b1, 1'b0, 0,  8'h55, 1, 144, 1'b0, 1'b0};
        vecs[5] = '{"81_after_reset", 16'h0281, 10, 1'b0, 1'b0, 0,  8'h81, 1, 144, 1'b0, 1'b0};
        vecs[6] = '{"12_8n1_dup_e24", 16'h0112, 9,  1'b0, 1'b1, 30, 8'h12, 1, 128, 1'b0, 1'b0};

        reset = 1'b1; tick = 1'b0; rxd = 1'b1; e24_e = 1'b0; e24_n = 1'b0;
        use_n = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_e", 32'(data_e), 32'd0);
        chk("reset_flags_e", 32'({valid_e, perror_e, ferror_e, busy_e, done_e}), 32'd0);
        chk("reset_flags_n", 32'({data_n, valid_n, perror_n, ferror_n, busy_n, done_n}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin
                // Abandon a frame with reset part-way through the data bits
                use_n = 1'b0;
                send_frame("abort", 16'h0281, 10, 1'b0, 60, 0);
                chk("abort_busy_before_reset", 32'(busy_e), 32'd1);
                @(negedge clk);
                reset = 1'b1; tick = 1'b0; rxd = 1'b1;
                @(posedge clk);
                #1;
                chk("abort_data_zero", 32'(data_e), 32'd0);
                chk("abort_flags_zero", 32'({valid_e, perror_e, ferror_e, busy_e, done_e}), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                clear_mon();
                for (int unsigned c = 0; c < 80; c++) clk_cycle((c % 4) == 3, 1'b1, 1'b0);
                chk("abort_no_done", done_cnt, 0);
                chk("abort_no_valid", valid_cnt, 0);
            end
            use_n = vecs[i].on_n;
            send_frame(vecs[i].name, vecs[i].line, vecs[i].nbits, vecs[i].glitch, 0, vecs[i].e24_again);
            chk({vecs[i].name, "_data"}, 32'(use_n ? data_n : data_e), 32'(vecs[i].exp_data));
            chk({vecs[i].name, "_valid_count"}, valid_cnt, vecs[i].exp_valid);
            chk({vecs[i].name, "_valid_tick"}, valid_tick, vecs[i].exp_vtick);
            chk({vecs[i].name, "_done_count"}, done_cnt, 1);
            chk({vecs[i].name, "_done_tick"}, done_tick, 16 * (vecs[i].nbits - 1));
            chk({vecs[i].name, "_perror"}, 32'(cur_errs()[1]), 32'(vecs[i].exp_perr));
            chk({vecs[i].name, "_ferror"}, 32'(cur_errs()[0]), 32'(vecs[i].exp_ferr));
            chk({vecs[i].name, "_busy_after"}, 32'(cur_busy()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
